// File: rtl/pcm_sample_fifo.sv
// pcm_sample_fifo: synchronous FIFO buffering PCM samples from a microphone
// capture stage to a consumer. Registered read port with one-cycle latency,
// registered occupancy/status flags and sticky overflow/underflow flags.
module pcm_sample_fifo #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              full_r;
  logic              empty_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_valid_r;
  logic              overflow_r;
  logic              underflow_r;

  logic              rd_accept_s;
  logic              wr_accept_s;
  logic              wr_drop_s;
  logic              rd_miss_s;
  logic [CNT_W-1:0]  count_next_s;

  // Accept decisions and next occupancy; a read only frees a slot when data exists, so no bypass on empty
  always_comb begin
    rd_accept_s  = 1'b0;
    wr_accept_s  = 1'b0;
    wr_drop_s    = 1'b0;
    rd_miss_s    = 1'b0;
    count_next_s = count_r;
    if (rd_en == 1'b1) begin
      rd_accept_s = ~empty_r;
      rd_miss_s   = empty_r;
    end else begin
      rd_accept_s = 1'b0;
      rd_miss_s   = 1'b0;
    end
    if (wr_en == 1'b1) begin
      wr_accept_s = (~full_r) | rd_accept_s;
      wr_drop_s   = full_r & ~rd_accept_s;
    end else begin
      wr_accept_s = 1'b0;
      wr_drop_s   = 1'b0;
    end
    case ({wr_accept_s, rd_accept_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Sample storage; contents are not cleared by reset, pointers make stale data unreachable
  always_ff @(posedge clk) begin
    if (!reset && wr_accept_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and registered full/empty derived from the next occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (wr_accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_accept_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CNT_DEPTH);
      empty_r <= (count_next_s == CNT_ZERO);
    end
  end

  // Registered read port: data holds its value unless a read is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r  <= {DATA_W{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_accept_s;
      if (rd_accept_s) begin
        rd_data_r <= mem_r[rd_ptr_r];
      end
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_drop_s) begin
        overflow_r <= 1'b1;
      end
      if (rd_miss_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;
  assign full      = full_r;
  assign empty     = empty_r;
  assign count     = count_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_pcm_sample_fifo.sv
// Testbench for pcm_sample_fifo: directed scenarios plus random traffic,
// checked against a queue-based reference model of FIFO behaviour.
module tb_pcm_sample_fifo;

  localparam int DATA_W = 6;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  pcm_sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_rd_data;
  logic              m_rd_valid;
  logic              m_ovf;
  logic              m_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},     32'(count),     32'(q.size()));
    check({tag, ".full"},      32'(full),      32'(q.size() == DEPTH));
    check({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
    check({tag, ".rd_valid"},  32'(rd_valid),  32'(m_rd_valid));
    check({tag, ".rd_data"},   32'(rd_data),   32'(m_rd_data));
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  // one clock: drive at negedge, update model at the edge, compare 1 time unit later
  task automatic cycle(input string tag, input logic r, input logic w,
                       input logic [DATA_W-1:0] wd, input logic rd);
    bit rd_ok;
    bit wr_ok;
    @(negedge clk);
    reset = r; wr_en = w; wr_data = wd; rd_en = rd;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_rd_data = '0; m_rd_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      rd_ok = rd && (q.size() > 0);
      wr_ok = w && ((q.size() < DEPTH) || rd_ok);
      if (rd && !rd_ok) m_unf = 1'b1;
      if (w && !wr_ok) m_ovf = 1'b1;
      if (rd_ok) begin
        m_rd_data  = q.pop_front();
        m_rd_valid = 1'b1;
      end else begin
        m_rd_valid = 1'b0;
      end
      if (wr_ok) q.push_back(wd);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
    q.delete();
    m_rd_data = '0; m_rd_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

    // reset with strobes asserted: nothing accepted
    cycle("rst0", 1'b1, 1'b1, 6'h2A, 1'b1);
    cycle("rst1", 1'b1, 1'b0, 6'h00, 1'b0);
    check("rst.empty_const", 32'(empty), 32'd1);
    check("rst.count_const", 32'(count), 32'd0);

    // fill with 0x01..0x10, then one dropped write
    for (int i = 1; i <= DEPTH; i++) cycle("fill", 1'b0, 1'b1, DATA_W'(i), 1'b0);
    check("fill.full_const", 32'(full), 32'd1);
    check("fill.count_const", 32'(count), 32'd16);
    check("fill.ovf_const", 32'(overflow), 32'd0);
    cycle("ovf", 1'b0, 1'b1, 6'h3F, 1'b0);
    check("ovf.flag_const", 32'(overflow), 32'd1);
    check("ovf.count_const", 32'(count), 32'd16);

    // drain: expect 0x01..0x10 in order
    for (int i = 1; i <= DEPTH; i++) begin
      cycle("drain", 1'b0, 1'b0, 6'h00, 1'b1);
      check("drain.seq_const", 32'(rd_data), 32'(i));
    end
    cycle("idle", 1'b0, 1'b0, 6'h00, 1'b0);
    check("idle.valid_low", 32'(rd_valid), 32'd0);

    // read while empty: underflow, data held
    cycle("unf", 1'b0, 1'b0, 6'h00, 1'b1);
    check("unf.data_held", 32'(rd_data), 32'h10);
    check("unf.flag_const", 32'(underflow), 32'd1);

    // full + simultaneous write/read: 0x2A comes out last
    cycle("rst2", 1'b1, 1'b0, 6'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle("fill2", 1'b0, 1'b1, DATA_W'($urandom_range(0, 63)), 1'b0);
    cycle("wr_rd_full", 1'b0, 1'b1, 6'h2A, 1'b1);
    check("wr_rd_full.ovf_const", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) cycle("drain2", 1'b0, 1'b0, 6'h00, 1'b1);
    check("drain2.last_const", 32'(rd_data), 32'h2A);

    // empty + simultaneous write/read: no bypass
    cycle("rst3", 1'b1, 1'b0, 6'h00, 1'b0);
    cycle("wr_rd_empty", 1'b0, 1'b1, 6'h15, 1'b1);
    check("wr_rd_empty.valid_const", 32'(rd_valid), 32'd0);
    check("wr_rd_empty.count_const", 32'(count), 32'd1);
    cycle("rd_after", 1'b0, 1'b0, 6'h00, 1'b1);
    check("rd_after.data_const", 32'(rd_data), 32'h15);

    // pointer wrap: 10 in / 10 out twice
    cycle("rst4", 1'b1, 1'b0, 6'h00, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) cycle("wrap_wr", 1'b0, 1'b1, DATA_W'($urandom_range(0, 63)), 1'b0);
      for (int i = 0; i < 10; i++) cycle("wrap_rd", 1'b0, 1'b0, 6'h00, 1'b1);
    end

    // reset mid-operation with 5 stored, flags set first
    cycle("unf2", 1'b0, 1'b0, 6'h00, 1'b1);
    for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b0, 1'b1, DATA_W'(i + 7), 1'b0);
    cycle("mid_rst", 1'b1, 1'b0, 6'h00, 1'b0);
    check("mid_rst.count_const", 32'(count), 32'd0);
    check("mid_rst.unf_const", 32'(underflow), 32'd0);
    cycle("post_rst", 1'b0, 1'b0, 6'h00, 1'b1);

    // random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      d = DATA_W'($urandom_range(0, 63));
      cycle("rand", ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 55), d,
            ($urandom_range(0, 99) < 45));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
